// File: rtl/enemy_sprite_animator_if.sv
// Pixel-side bundle between the enemy mover/bracket stage, this animator and the video mux.
interface enemy_sprite_animator_if;
    logic        startOfFrame;
    logic        inDrawingRequest;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        missileDrawingRequest;
    logic        restart;
    logic [7:0]  RGBout;
    logic        drawingRequest;
    logic        hit;
    logic        alive;

    modport master (
        output startOfFrame, inDrawingRequest, offsetX, offsetY,
               missileDrawingRequest, restart,
        input  RGBout, drawingRequest, hit, alive
    );

    modport slave (
        input  startOfFrame, inDrawingRequest, offsetX, offsetY,
               missileDrawingRequest, restart,
        output RGBout, drawingRequest, hit, alive
    );
endinterface

// File: rtl/enemy_sprite_animator.sv
// Enemy sprite colouring plus life cycle: two-frame walk, pixel-exact missile hit,
// blinking hit-flash and dead state. One register stage on the pixel path.
module enemy_sprite_animator #(
    parameter int         OBJECT_WIDTH_X       = 30,
    parameter int         OBJECT_HEIGHT_Y      = 30,
    parameter int         FRAMES_PER_ANIM      = 8,
    parameter int         FLASH_FRAMES         = 32,
    parameter int         BLINK_PERIOD         = 4,
    parameter logic [7:0] HIT_COLOR            = 8'hE0,
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF
) (
    input logic                     clk,
    input logic                     resetN,
    enemy_sprite_animator_if.slave  bus
);
    localparam int ANIM_W  = (FRAMES_PER_ANIM > 1) ? $clog2(FRAMES_PER_ANIM) : 1;
    localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic [1:0] {ALIVE, FLASH, DEAD} state_t;

    state_t              state, state_next;
    logic [ANIM_W-1:0]   anim_cnt, anim_cnt_next;
    logic                anim_frame, anim_frame_next;
    logic [FLASH_W-1:0]  flash_cnt, flash_cnt_next;
    logic                coll_pending, coll_pending_next;
    logic                hit_next;
    logic [7:0]          rgb_q, rgb_next;
    logic                draw_q, draw_next;
    logic                hit_q;
    logic [7:0]          pix;
    logic                opaque, coll, lit;

    // Sprite art: a diamond body with two legs whose columns alternate between frames.
    function automatic logic [7:0] rom_pixel(input logic frame, input logic [10:0] x,
                                             input logic [10:0] y);
        logic signed [12:0] dx, dy;
        logic               body, leg;
        dx = $signed({2'b00, x}) - 13'sd15;
        dy = $signed({2'b00, y}) - 13'sd15;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        body = (dx + dy) <= 13'sd13;
        if (frame)
            leg = (y >= 11'd26) && (x == 11'd11 || x == 11'd12 || x == 11'd17 || x == 11'd18);
        else
            leg = (y >= 11'd26) && (x == 11'd8 || x == 11'd9 || x == 11'd20 || x == 11'd21);
        return (body || leg) ? {1'b0, frame, x[2:0], y[2:0]} : TRANSPARENT_ENCODING;
    endfunction

    always_comb begin
        if (int'(bus.offsetX) >= OBJECT_WIDTH_X || int'(bus.offsetY) >= OBJECT_HEIGHT_Y)
            pix = TRANSPARENT_ENCODING;
        else
            pix = rom_pixel(anim_frame, bus.offsetX, bus.offsetY);
        opaque = bus.inDrawingRequest && (pix != TRANSPARENT_ENCODING);
        coll   = opaque && bus.missileDrawingRequest && (state == ALIVE);
        lit    = ((int'(flash_cnt) / BLINK_PERIOD) % 2) == 0;
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state        <= ALIVE;
            anim_cnt     <= '0;
            anim_frame   <= 1'b0;
            flash_cnt    <= '0;
            coll_pending <= 1'b0;
            hit_q        <= 1'b0;
            rgb_q        <= TRANSPARENT_ENCODING;
            draw_q       <= 1'b0;
        end else begin
            state        <= state_next;
            anim_cnt     <= anim_cnt_next;
            anim_frame   <= anim_frame_next;
            flash_cnt    <= flash_cnt_next;
            coll_pending <= coll_pending_next;
            hit_q        <= hit_next;
            rgb_q        <= rgb_next;
            draw_q       <= draw_next;
        end
    end

    // Restart beats both a frame boundary and a collision arriving on the same cycle.
    always_comb begin
        state_next        = state;
        anim_cnt_next     = anim_cnt;
        anim_frame_next   = anim_frame;
        flash_cnt_next    = flash_cnt;
        coll_pending_next = coll_pending;
        hit_next          = 1'b0;
        if (bus.restart) begin
            state_next        = ALIVE;
            anim_cnt_next     = '0;
            anim_frame_next   = 1'b0;
            flash_cnt_next    = '0;
            coll_pending_next = 1'b0;
        end else begin
            case (state)
                ALIVE: begin
                    if (bus.startOfFrame) begin
                        if (coll_pending || coll) begin
                            state_next        = FLASH;
                            flash_cnt_next    = '0;
                            coll_pending_next = 1'b0;
                            hit_next          = 1'b1;
                        end else if (anim_cnt == ANIM_W'(FRAMES_PER_ANIM - 1)) begin
                            anim_cnt_next   = '0;
                            anim_frame_next = ~anim_frame;
                        end else begin
                            anim_cnt_next = anim_cnt + 1'b1;
                        end
                    end else if (coll) begin
                        coll_pending_next = 1'b1;
                    end
                end
                FLASH: begin
                    if (bus.startOfFrame) begin
                        if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1))
                            state_next = DEAD;
                        else
                            flash_cnt_next = flash_cnt + 1'b1;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        draw_next = 1'b0;
        rgb_next  = TRANSPARENT_ENCODING;
        case (state)
            ALIVE: begin
                draw_next = opaque;
                rgb_next  = opaque ? pix : TRANSPARENT_ENCODING;
            end
            FLASH: begin
                draw_next = opaque && lit;
                rgb_next  = (opaque && lit) ? HIT_COLOR : TRANSPARENT_ENCODING;
            end
            default: begin
                draw_next = 1'b0;
                rgb_next  = TRANSPARENT_ENCODING;
            end
        endcase
    end

    assign bus.RGBout         = rgb_q;
    assign bus.drawingRequest = draw_q;
    assign bus.hit            = hit_q;
    assign bus.alive          = (state == ALIVE);
endmodule

// File: tb/tb_enemy_sprite_animator.sv
// Bench for enemy_sprite_animator: pixel vector table, life-cycle sequences and a
// randomized run against a frame-counting reference model.
module tb_enemy_sprite_animator;
    localparam int         FPA  = 8;
    localparam int         FLF  = 32;
    localparam int         BLK  = 4;
    localparam logic [7:0] HITC = 8'hE0;
    localparam logic [7:0] TR   = 8'hFF;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    enemy_sprite_animator_if bus();

    enemy_sprite_animator #(
        .OBJECT_WIDTH_X(30), .OBJECT_HEIGHT_Y(30), .FRAMES_PER_ANIM(FPA),
        .FLASH_FRAMES(FLF), .BLINK_PERIOD(BLK), .HIT_COLOR(HITC),
        .TRANSPARENT_ENCODING(TR)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: state 0=alive 1=flash 2=dead, whole-frame counts since (re)arm.
    int         m_state;
    int         m_aframes;
    int         m_fframes;
    bit         m_pend;
    logic [7:0] e_rgb;
    logic       e_draw, e_hit, e_alive;

    function automatic logic [7:0] ref_pix(input int frame, input int x, input int y);
        int ax, ay;
        bit body, leg;
        if (x >= 30 || y >= 30) return TR;
        ax = (x > 15) ? x - 15 : 15 - x;
        ay = (y > 15) ? y - 15 : 15 - y;
        body = (ax + ay) <= 13;
        if (frame == 0) leg = (y >= 26) && (x == 8 || x == 9 || x == 20 || x == 21);
        else            leg = (y >= 26) && (x == 11 || x == 12 || x == 17 || x == 18);
        if (!(body || leg)) return TR;
        return 8'(64 * frame + 8 * (x % 8) + (y % 8));
    endfunction

    task automatic model_clear();
        m_state = 0; m_aframes = 0; m_fframes = 0; m_pend = 0;
    endtask

    task automatic model_reset();
        model_clear();
        e_rgb = TR; e_draw = 1'b0; e_hit = 1'b0; e_alive = 1'b1;
    endtask

    task automatic cycle(input bit sof, input bit drq, input int x, input int y,
                         input bit mis, input bit rs);
        logic [7:0] p;
        bit op, coll, lit;
        bus.startOfFrame          = sof;
        bus.inDrawingRequest      = drq;
        bus.offsetX               = 11'(x);
        bus.offsetY               = 11'(y);
        bus.missileDrawingRequest = mis;
        bus.restart               = rs;
        p  = ref_pix((m_aframes / FPA) % 2, x, y);
        op = drq && (p != TR);
        case (m_state)
            0: begin e_draw = op; e_rgb = op ? p : TR; end
            1: begin
                lit = ((m_fframes / BLK) % 2) == 0;
                e_draw = op && lit;
                e_rgb = (op && lit) ? HITC : TR;
            end
            default: begin e_draw = 1'b0; e_rgb = TR; end
        endcase
        e_hit = 1'b0;
        if (rs) begin
            model_clear();
        end else if (m_state == 0) begin
            coll = op && mis;
            if (sof) begin
                if (m_pend || coll) begin
                    m_state = 1; m_fframes = 0; m_pend = 0; e_hit = 1'b1;
                end else begin
                    m_aframes++;
                end
            end else if (coll) begin
                m_pend = 1;
            end
        end else if (m_state == 1 && sof) begin
            if (m_fframes == FLF - 1) m_state = 2;
            else m_fframes++;
        end
        e_alive = (m_state == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        chk({name, "_rgb"},   bus.RGBout,         e_rgb);
        chk({name, "_draw"},  bus.drawingRequest, e_draw);
        chk({name, "_hit"},   bus.hit,            e_hit);
        chk({name, "_alive"}, bus.alive,          e_alive);
    endtask

    typedef struct {
        bit         drq;
        int         x;
        int         y;
        bit         exp_draw;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1,    5,  7, 1'b0, 8'hFF};
        vecs[1]  = '{1'b1,   30,  0, 1'b0, 8'hFF};
        vecs[2]  = '{1'b1,   15, 15, 1'b1, 8'h3F};
        vecs[3]  = '{1'b0,   15, 15, 1'b0, 8'hFF};
        vecs[4]  = '{1'b1,   10, 15, 1'b1, 8'h17};
        vecs[5]  = '{1'b1,    9, 27, 1'b1, 8'h0B};
        vecs[6]  = '{1'b1,   11, 27, 1'b0, 8'hFF};
        vecs[7]  = '{1'b1,   15,  2, 1'b1, 8'h3A};
        vecs[8]  = '{1'b1,   15,  1, 1'b0, 8'hFF};
        vecs[9]  = '{1'b1,   20, 30, 1'b0, 8'hFF};
        vecs[10] = '{1'b1,   20, 29, 1'b1, 8'h25};
        vecs[11] = '{1'b1, 2000,  5, 1'b0, 8'hFF};
        vecs[12] = '{1'b1,   29, 15, 1'b0, 8'hFF};
        vecs[13] = '{1'b1,   28, 15, 1'b1, 8'h27};

        bus.startOfFrame = 0; bus.inDrawingRequest = 0; bus.offsetX = '0;
        bus.offsetY = '0; bus.missileDrawingRequest = 0; bus.restart = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb",   bus.RGBout,         TR);
        chk("reset_draw",  bus.drawingRequest, 1'b0);
        chk("reset_hit",   bus.hit,            1'b0);
        chk("reset_alive", bus.alive,          1'b1);
        @(negedge clk);
        resetN = 1'b0;

        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].drq, vecs[i].x, vecs[i].y, 1'b0, 1'b0);
            chk($sformatf("vec%0d_draw", i), bus.drawingRequest, vecs[i].exp_draw);
            chk($sformatf("vec%0d_rgb", i),  bus.RGBout,         vecs[i].exp_rgb);
        end

        // Walk animation: frame toggles every 8 boundaries
        repeat (8) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("anim1_centre", bus.RGBout, 8'h7F);
        cycle(1'b0, 1'b1, 9, 27, 1'b0, 1'b0);
        chk("anim1_oldleg_draw", bus.drawingRequest, 1'b0);
        cycle(1'b0, 1'b1, 11, 27, 1'b0, 1'b0);
        chk("anim1_newleg", bus.RGBout, 8'h5B);
        repeat (8) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("anim0_again", bus.RGBout, 8'h3F);

        // Missile over a transparent pixel does nothing; over an opaque one it hits
        cycle(1'b0, 1'b1, 5, 7, 1'b1, 1'b0);
        chk("miss_transp_draw", bus.drawingRequest, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("miss_transp_hit", bus.hit, 1'b0);
        chk("miss_transp_alive", bus.alive, 1'b1);
        cycle(1'b0, 1'b1, 15, 15, 1'b1, 1'b0);
        chk("coll_pixel", bus.RGBout, 8'h3F);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("pending_hit_low", bus.hit, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("hit_pulse", bus.hit, 1'b1);
        chk("hit_alive_low", bus.alive, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("hit_one_cycle", bus.hit, 1'b0);

        // Flash blink (missile held on, ignored) then dead
        for (int k = 0; k < FLF; k++) begin
            cycle(1'b0, 1'b1, 15, 15, 1'b1, 1'b0);
            chk($sformatf("flash%0d_draw", k), bus.drawingRequest, ((k / 4) % 2) == 0);
            chk($sformatf("flash%0d_rgb", k), bus.RGBout, (((k / 4) % 2) == 0) ? HITC : TR);
            cycle(1'b1, 1'b1, 15, 15, 1'b1, 1'b0);
            chk($sformatf("flash%0d_hit", k), bus.hit, 1'b0);
        end
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("dead_draw", bus.drawingRequest, 1'b0);
        chk("dead_rgb", bus.RGBout, TR);
        chk("dead_alive", bus.alive, 1'b0);
        cycle(1'b1, 1'b1, 15, 15, 1'b1, 1'b0);
        chk("dead_stays", bus.alive, 1'b0);

        // Restart priority
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("restart_alive", bus.alive, 1'b1);
        cycle(1'b1, 1'b1, 15, 15, 1'b1, 1'b0);
        chk("sof_coll_hit", bus.hit, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("rst_sof_alive", bus.alive, 1'b1);
        chk("rst_sof_nohit", bus.hit, 1'b0);
        cycle(1'b0, 1'b1, 9, 27, 1'b0, 1'b0);
        chk("rst_frame0", bus.RGBout, 8'h0B);
        cycle(1'b0, 1'b1, 15, 15, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("rst_coll_nohit", bus.hit, 1'b0);
        chk("rst_coll_alive", bus.alive, 1'b1);
        cycle(1'b1, 1'b1, 15, 15, 1'b1, 1'b0);
        chk("rehit", bus.hit, 1'b1);
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("reflash_lit", bus.RGBout, HITC);
        repeat (4) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("reflash_dark", bus.drawingRequest, 1'b0);

        // Asynchronous reset between edges while flashing
        repeat (4) cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 15, 15, 1'b0, 1'b0);
        chk("prereset_lit", bus.RGBout, HITC);
        #2 resetN = 1'b1;
        #1;
        chk("async_rgb",   bus.RGBout,         TR);
        chk("async_draw",  bus.drawingRequest, 1'b0);
        chk("async_hit",   bus.hit,            1'b0);
        chk("async_alive", bus.alive,          1'b1);
        model_reset();
        @(negedge clk);
        resetN = 1'b0;
        cycle(1'b0, 1'b1, 9, 27, 1'b0, 1'b0);
        chk("post_async_frame0", bus.RGBout, 8'h0B);
        chk("post_async_alive", bus.alive, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(19, 0) == 0, $urandom_range(3, 0) != 0,
                  int'($urandom_range(33, 0)), int'($urandom_range(33, 0)),
                  $urandom_range(5, 0) == 0, $urandom_range(249, 0) == 0);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
